// File: rtl/board_settle_unit.sv
// Commits a landed tile into the matrix memory and removes full rows, compacting the rest downward.
// Optional BOARD_SETTLE_STATS_EN adds a running total of removed rows on total_lines_o.
module board_settle_unit #(
  parameter int unsigned width_p  = 10,
  parameter int unsigned height_p = 20
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        commit_v_i,
  input  logic                        check_v_i,
  output logic                        done_o,
  input  logic [7:0]                  pos_x_i,
  input  logic [7:0]                  pos_y_i,
  input  logic [15:0]                 shape_i,
  input  logic [15:0]                 shape_on_board_i,
  output logic                        empty_o,
  output logic [7:0]                  mm_block_x_o,
  output logic [7:0]                  mm_block_y_o,
  output logic [15:0]                 mm_block_data_o,
  output logic                        mm_block_v_o,
  input  logic                        mm_is_ready_i,
  output logic [$clog2(height_p)-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]          mm_read_data_i,
  output logic [$clog2(height_p)-1:0] mm_write_addr_o,
  output logic [width_p-1:0]          mm_write_data_o,
  output logic                        mm_write_v_o,
  output logic [2:0]                  combine_number_o
`ifdef BOARD_SETTLE_STATS_EN
  ,
  output logic [15:0]                 total_lines_o
`endif
);

  localparam int unsigned addr_w_lp = $clog2(height_p);
  localparam logic [addr_w_lp-1:0] last_row_lp = addr_w_lp'(height_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMMIT_WAIT,
    COMMIT_WR,
    SCAN,
    FILL,
    DONE,
    HOLD
  } state_e;

  state_e               state_r, state_n;
  logic [addr_w_lp-1:0] rd_r, rd_n;
  logic [addr_w_lp-1:0] wr_r, wr_n;
  logic [2:0]           count_r, count_n;
  logic                 is_check_r, is_check_n;
  logic                 row_full;

  assign row_full        = &mm_read_data_i;
  assign mm_block_x_o    = pos_x_i;
  assign mm_block_y_o    = pos_y_i;
  assign mm_block_data_o = shape_i | shape_on_board_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r          <= IDLE;
      rd_r             <= last_row_lp;
      wr_r             <= last_row_lp;
      count_r          <= '0;
      is_check_r       <= 1'b0;
      combine_number_o <= '0;
    end else begin
      state_r    <= state_n;
      rd_r       <= rd_n;
      wr_r       <= wr_n;
      count_r    <= count_n;
      is_check_r <= is_check_n;
      if (state_r == DONE && is_check_r) begin
        combine_number_o <= count_r;
      end
    end
  end

`ifdef BOARD_SETTLE_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      total_lines_o <= '0;
    end else if (state_r == DONE && is_check_r) begin
      total_lines_o <= total_lines_o + 16'(count_r);
    end
  end
`endif

  always_comb begin
    state_n         = state_r;
    rd_n            = rd_r;
    wr_n            = wr_r;
    count_n         = count_r;
    is_check_n      = is_check_r;
    done_o          = 1'b0;
    empty_o         = 1'b0;
    mm_block_v_o    = 1'b0;
    mm_write_v_o    = 1'b0;
    mm_read_addr_o  = rd_r;
    mm_write_addr_o = wr_r;
    mm_write_data_o = '0;

    case (state_r)
      IDLE: begin
        if (commit_v_i) begin
          is_check_n = 1'b0;
          state_n    = COMMIT_WAIT;
        end else if (check_v_i) begin
          is_check_n = 1'b1;
          rd_n       = last_row_lp;
          wr_n       = last_row_lp;
          count_n    = '0;
          state_n    = SCAN;
        end
      end

      COMMIT_WAIT: begin
        if (mm_is_ready_i) begin
          state_n = COMMIT_WR;
        end
      end

      COMMIT_WR: begin
        mm_block_v_o = 1'b1;
        state_n      = DONE;
      end

      SCAN: begin
        // Surviving rows are copied down to wr; wr only lags rd once a full row is skipped.
        if (row_full) begin
          count_n = (count_r == 3'd7) ? 3'd7 : count_r + 3'd1;
        end else begin
          mm_write_v_o    = 1'b1;
          mm_write_data_o = mm_read_data_i;
          wr_n            = wr_r - 1'b1;
        end
        if (rd_r == '0) begin
          state_n = (count_n == '0) ? DONE : FILL;
        end else begin
          rd_n = rd_r - 1'b1;
        end
      end

      FILL: begin
        mm_write_v_o = 1'b1;
        if (wr_r == '0) begin
          state_n = DONE;
        end else begin
          wr_n = wr_r - 1'b1;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        empty_o = ~is_check_r;
        state_n = HOLD;
      end

      HOLD: begin
        if (!commit_v_i && !check_v_i) begin
          rd_n    = last_row_lp;
          wr_n    = last_row_lp;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_settle_unit.sv
// Randomized self-checking bench for board_settle_unit with a behavioural matrix-memory model.
module tb_board_settle_unit;
  localparam int unsigned W  = 10;
  localparam int unsigned H  = 20;
  localparam int unsigned AW = $clog2(H);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          commit_v_i, check_v_i, done_o, empty_o;
  logic [7:0]    pos_x_i, pos_y_i, mm_block_x_o, mm_block_y_o;
  logic [15:0]   shape_i, shape_on_board_i, mm_block_data_o;
  logic          mm_block_v_o, mm_is_ready_i, mm_write_v_o;
  logic [AW-1:0] mm_read_addr_o, mm_write_addr_o;
  logic [W-1:0]  mm_read_data_i, mm_write_data_o;
  logic [2:0]    combine_number_o;
`ifdef BOARD_SETTLE_STATS_EN
  logic [15:0]   total_lines_o;
`endif

  logic [H-1:0][W-1:0] board, load_img;
  logic                load_en = 1'b0;
  int                  pass_cnt = 0;
  int                  total_cnt = 0;
  int                  both_hi = 0;
  logic [2:0]          exp_combine = '0;
  logic [15:0]         exp_total = '0;

  board_settle_unit #(.width_p(W), .height_p(H)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .commit_v_i(commit_v_i), .check_v_i(check_v_i),
    .done_o(done_o), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .shape_i(shape_i),
    .shape_on_board_i(shape_on_board_i), .empty_o(empty_o), .mm_block_x_o(mm_block_x_o),
    .mm_block_y_o(mm_block_y_o), .mm_block_data_o(mm_block_data_o), .mm_block_v_o(mm_block_v_o),
    .mm_is_ready_i(mm_is_ready_i), .mm_read_addr_o(mm_read_addr_o), .mm_read_data_i(mm_read_data_i),
    .mm_write_addr_o(mm_write_addr_o), .mm_write_data_o(mm_write_data_o), .mm_write_v_o(mm_write_v_o),
    .combine_number_o(combine_number_o)
`ifdef BOARD_SETTLE_STATS_EN
    , .total_lines_o(total_lines_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Matrix memory: combinational row read, synchronous row write.
  assign mm_read_data_i = board[mm_read_addr_o];
  always @(posedge clk_i) begin
    if (load_en) board <= load_img;
    else if (mm_write_v_o) board[mm_write_addr_o] <= mm_write_data_o;
  end

  always @(negedge clk_i) if (mm_block_v_o && mm_write_v_o) both_hi++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: drop full rows, let the survivors fall to the bottom in order.
  function automatic void model(input logic [H-1:0][W-1:0] img,
                                output logic [H-1:0][W-1:0] res, output int removed);
    logic [W-1:0] kept[$];
    res = '0;
    removed = 0;
    for (int r = H - 1; r >= 0; r--) begin
      if (img[r] == '1) removed++;
      else kept.push_back(img[r]);
    end
    for (int i = 0; i < kept.size(); i++) res[H-1-i] = kept[i];
  endfunction

  function automatic logic [H-1:0][W-1:0] rand_board(input int unsigned pfull);
    logic [H-1:0][W-1:0] b;
    logic [W-1:0] v;
    for (int r = 0; r < H; r++) begin
      v = W'($urandom);
      v[$urandom_range(W - 1)] = 1'b0;
      b[r] = ($urandom_range(99) < pfull) ? '1 : v;
    end
    return b;
  endfunction

  task automatic load_board(input logic [H-1:0][W-1:0] img);
    @(negedge clk_i);
    load_img = img;
    load_en  = 1'b1;
    @(negedge clk_i);
    load_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total_cnt++;
    if ({done_o, empty_o, mm_block_v_o, mm_write_v_o} !== 4'b0) $display("FAIL reset_strobes: got %b required 0000", {done_o, empty_o, mm_block_v_o, mm_write_v_o});
    else pass_cnt++;
    total_cnt++;
    if (combine_number_o !== 3'd0) $display("FAIL reset_combine: got %0d required 0", combine_number_o);
    else pass_cnt++;
    total_cnt++;
    if (mm_read_addr_o !== AW'(H - 1) || mm_write_addr_o !== AW'(H - 1)) $display("FAIL reset_pointers: got rd=%0d wr=%0d required %0d", mm_read_addr_o, mm_write_addr_o, H - 1);
    else pass_cnt++;
    reset_i = 1'b0;
  endtask

  // Requests stay high well past done to confirm a held request is not re-executed.
  task automatic run_commit(input logic [7:0] x, input logic [7:0] y, input logic [15:0] shp,
                            input logic [15:0] sob, input int d, input bit both, input string nm);
    int blk_n = 0, blk_k = -1, done_n = 0, done_k = -1, emp_n = 0, wr_n = 0;
    logic emp_at_done = 1'b0;
    logic [15:0] bd = '0;
    logic [7:0] bx = '0, by = '0;
    @(negedge clk_i);
    pos_x_i = x; pos_y_i = y; shape_i = shp; shape_on_board_i = sob;
    mm_is_ready_i = 1'b0;
    commit_v_i = 1'b1;
    check_v_i  = both;
    for (int k = 1; k <= d + 10; k++) begin
      @(negedge clk_i);
      if (mm_block_v_o) begin blk_n++; blk_k = k; bd = mm_block_data_o; bx = mm_block_x_o; by = mm_block_y_o; end
      if (done_o) begin done_n++; done_k = k; emp_at_done = empty_o; end
      if (empty_o) emp_n++;
      if (mm_write_v_o) wr_n++;
      if (k >= d + 1) mm_is_ready_i = 1'b1;
    end
    commit_v_i = 1'b0;
    check_v_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    total_cnt++;
    if (blk_n !== 1 || blk_k !== d + 2) $display("FAIL %s_strobe: got %0d strobes at cycle %0d required 1 at cycle %0d", nm, blk_n, blk_k, d + 2);
    else pass_cnt++;
    total_cnt++;
    if (bd !== (shp | sob) || bx !== x || by !== y) $display("FAIL %s_block: got data=%h x=%h y=%h required data=%h x=%h y=%h", nm, bd, bx, by, shp | sob, x, y);
    else pass_cnt++;
    total_cnt++;
    if (done_n !== 1 || done_k !== d + 3) $display("FAIL %s_done: got %0d pulses at cycle %0d required 1 at cycle %0d", nm, done_n, done_k, d + 3);
    else pass_cnt++;
    total_cnt++;
    if (emp_n !== 1 || emp_at_done !== 1'b1) $display("FAIL %s_empty: got %0d pulses, with_done=%b required 1, 1", nm, emp_n, emp_at_done);
    else pass_cnt++;
    total_cnt++;
    if (wr_n !== 0 || combine_number_o !== exp_combine) $display("FAIL %s_side_effects: got writes=%0d combine=%0d required 0, %0d", nm, wr_n, combine_number_o, exp_combine);
    else pass_cnt++;
  endtask

  task automatic run_check(input logic [H-1:0][W-1:0] img, input string nm);
    logic [H-1:0][W-1:0] exp_b;
    int removed, done_n = 0, done_k = -1, wr_n = 0, blk_n = 0, emp_n = 0;
    logic [2:0] exp_c;
    load_board(img);
    model(img, exp_b, removed);
    exp_c = (removed > 7) ? 3'd7 : 3'(removed);
    @(negedge clk_i);
    check_v_i = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk_i);
      if (done_o) begin done_n++; done_k = k; end
      if (mm_write_v_o) wr_n++;
      if (mm_block_v_o) blk_n++;
      if (empty_o) emp_n++;
    end
    check_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_combine = exp_c;
    exp_total   = exp_total + 16'(exp_c);
    total_cnt++;
    if (done_n !== 1 || done_k !== 21 + removed) $display("FAIL %s_done: got %0d pulses at cycle %0d required 1 at cycle %0d", nm, done_n, done_k, 21 + removed);
    else pass_cnt++;
    total_cnt++;
    if (wr_n !== 20 || blk_n !== 0 || emp_n !== 0) $display("FAIL %s_strobes: got writes=%0d blocks=%0d empty=%0d required 20, 0, 0", nm, wr_n, blk_n, emp_n);
    else pass_cnt++;
    total_cnt++;
    if (board !== exp_b) $display("FAIL %s_board: got %h required %h", nm, board, exp_b);
    else pass_cnt++;
    total_cnt++;
    if (combine_number_o !== exp_c) $display("FAIL %s_combine: got %0d required %0d", nm, combine_number_o, exp_c);
    else pass_cnt++;
`ifdef BOARD_SETTLE_STATS_EN
    total_cnt++;
    if (total_lines_o !== exp_total) $display("FAIL %s_total: got %0d required %0d", nm, total_lines_o, exp_total);
    else pass_cnt++;
`endif
  endtask

  task automatic test_commit();
    run_commit(8'd3, 8'd0, 16'h0066, 16'h0000, 0, 1'b0, "commit_basic");
    for (int i = 0; i < 4; i++)
      run_commit(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(3)), 1'b0, "commit_rand");
  endtask

  task automatic test_commit_backpressure();
    run_commit(8'hFE, 8'd5, 16'h0F00, 16'h1001, 5, 1'b0, "commit_bp");
  endtask

  task automatic test_check_two_lines();
    logic [H-1:0][W-1:0] b = '0;
    b[19] = '1;
    b[18] = '1;
    b[17] = W'(1);
    run_check(b, "check_two");
  endtask

  task automatic test_check_random();
    run_check(rand_board(0), "check_none_full");
    for (int i = 0; i < 4; i++) run_check(rand_board(30), "check_rand");
    run_check(rand_board(60), "check_many");
    run_check('1, "check_all_full");
  endtask

  task automatic test_simultaneous();
    run_commit(8'd1, 8'd2, 16'h4E00, 16'h0003, 1, 1'b1, "simultaneous");
  endtask

  task automatic test_reset_mid_scan();
    load_board(rand_board(40));
    @(negedge clk_i);
    check_v_i = 1'b1;
    repeat (8) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    total_cnt++;
    if ({done_o, mm_block_v_o, mm_write_v_o} !== 3'b0) $display("FAIL midreset_strobes: got %b required 000", {done_o, mm_block_v_o, mm_write_v_o});
    else pass_cnt++;
    total_cnt++;
    if (combine_number_o !== 3'd0 || mm_read_addr_o !== AW'(H - 1)) $display("FAIL midreset_state: got combine=%0d rd=%0d required 0, %0d", combine_number_o, mm_read_addr_o, H - 1);
    else pass_cnt++;
    exp_combine = '0;
    exp_total   = '0;
    @(negedge clk_i);
    reset_i   = 1'b0;
    check_v_i = 1'b0;
    @(negedge clk_i);
    run_check(board, "check_after_reset");
  endtask

  task automatic test_exclusive();
    total_cnt++;
    if (both_hi !== 0) $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", both_hi);
    else pass_cnt++;
  endtask

  initial begin
    reset_i = 1'b1;
    commit_v_i = 1'b0; check_v_i = 1'b0; mm_is_ready_i = 1'b0;
    pos_x_i = '0; pos_y_i = '0; shape_i = '0; shape_on_board_i = '0;
    load_img = '0;
    test_reset();
    load_board('0);
    test_commit();
    test_commit_backpressure();
    test_check_two_lines();
    test_check_random();
    test_simultaneous();
    test_reset_mid_scan();
    test_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/board_settle_unit.md
Name: board_settle_unit

Overview:
- Settles a landed tetromino into the playfield matrix memory, then clears completed rows.
- Merges the current tile's 4x4 shape into the board (commit) and signals the tile store to empty itself.
- Check operation: scans the board bottom-up, deletes full rows, compacts the remaining rows downward and reports how many rows were removed.
- Sits between the game FSM (level start/done handshake) and the matrix memory (combinational read ports, synchronous write ports).

Parameters:
- width_p, 10, board columns (row word width).
- height_p, 20, board rows. Row 0 is the top; row height_p-1 is the bottom.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- commit_v_i  in  1  level request: commit the current tile
- check_v_i  in  1  level request: eliminate full rows
- done_o  out  1  one-cycle pulse: requested operation finished
- pos_x_i  in  8  signed tile column of the shape's upper-left cell
- pos_y_i  in  8  signed tile row of the shape's upper-left cell
- shape_i  in  16  tile cells; bit [4*r+c] is row r, column c
- shape_on_board_i  in  16  board cells under the 4x4 window at pos (combinational)
- empty_o  out  1  one-cycle pulse telling the tile store to clear
- mm_block_x_o  out  8  block write column (equals pos_x_i)
- mm_block_y_o  out  8  block write row (equals pos_y_i)
- mm_block_data_o  out  16  merged block (shape_i OR shape_on_board_i)
- mm_block_v_o  out  1  block write strobe
- mm_is_ready_i  in  1  matrix memory can accept a block write
- mm_read_addr_o  out  $clog2(height_p)  row read address
- mm_read_data_i  in  width_p  row data (combinational, same cycle)
- mm_write_addr_o  out  $clog2(height_p)  row write address
- mm_write_data_o  out  width_p  row write data
- mm_write_v_o  out  1  row write strobe
- combine_number_o  out  3  rows removed by the last check

Behaviour:
- Reset (async): state IDLE; all strobes 0; combine_number_o=0; pointers=height_p-1.
- FSM states: IDLE, COMMIT_WAIT, COMMIT_WR, SCAN, FILL, DONE, HOLD.
- Request arbitration in IDLE:
  - commit_v_i has priority over check_v_i when both are high.
  - commit_v_i -> COMMIT_WAIT.
  - check_v_i -> SCAN; rd=wr=height_p-1; count=0.
- COMMIT_WAIT:
  - Stays until mm_is_ready_i=1.
  - Then drives mm_block_v_o=1 for exactly one cycle (COMMIT_WR) with the merged data and pos.
  - Cells outside the board are ignored by the memory; this unit does not clip them.
- COMMIT_WR -> DONE. In DONE, empty_o=1 together with done_o when the operation was a commit.
- SCAN, one row per cycle:
  - mm_read_addr_o=rd.
  - Row all ones: count saturates at 7; no write.
  - Otherwise: write mm_read_data_i to address wr with mm_write_v_o=1, then wr--.
  - rd-- in both cases.
  - Writes with wr==rd are allowed (rewrite the same data).
  - After processing row 0: if count==0 -> DONE; else -> FILL.
- FILL: writes 0 to rows wr down to 0, one per cycle, then -> DONE.
- DONE:
  - done_o=1 for one cycle.
  - combine_number_o<=count on a check (commit leaves it unchanged); held until the next check completes.
  - -> HOLD.
- HOLD: waits until commit_v_i=0 and check_v_i=0, then -> IDLE. A request held high is never re-executed.
- Deasserting a request mid-operation does not abort it.
- Check latency: height_p cycles of scan, plus count fill cycles, plus 1 done cycle.
- Commit latency: at least 2 cycles after the request, plus cycles spent waiting for mm_is_ready_i.
- Only one of mm_block_v_o / mm_write_v_o is ever high in a cycle.

Optional Feature:
- Macro BOARD_SETTLE_STATS_EN.
- Defined: adds output total_lines_o [15:0].
  - Async-reset to 0.
  - Adds count at every check DONE.
  - Wraps modulo 2^16.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Commit: empty board, pos=(3,0), shape=0x0066.
  - Response: one mm_block_v_o with data 0x0066 at (3,0).
  - Then done_o and empty_o pulse together.
  - combine_number_o unchanged.
- Commit backpressure: hold mm_is_ready_i=0 for 5 cycles.
  - Response: no strobe during those cycles.
  - Strobe in the cycle after ready rises; done_o one cycle later.
- Check, two lines: rows 19 and 18 full, row 17=0x001.
  - Response: row19<=0x001; rows 18..0 written with their shifted contents, then 0.
  - combine_number_o=2; done_o after 20+2+1 cycles.
- Check, none full: arbitrary board.
  - Response: 20 self-rewrites, no FILL, combine_number_o=0.
- Simultaneous commit_v_i=check_v_i=1 from IDLE.
  - Response: commit executes first.
  - After done_o, no new operation starts until both requests drop.
- Reset asserted in the middle of SCAN.
  - Response: strobes go to 0 immediately; combine_number_o=0; next check_v_i starts a fresh scan from row 19.
